keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad and debounces key presses.

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x4 active-low keypad matrix, debounces presses and releases, encodes the key to hex.
// Latency: a stable press raises key_pressed within 4*SCAN_DIV + DEBOUNCE_CYCLES + 3 clk cycles.
// Backpressure: none; key_pressed is a level held for exactly one debounced press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_value,
    output logic       key_pressed
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Row synchronizer
    logic [3:0]       r_row_sync1;
    logic [3:0]       r_row_s;

    // Scan / FSM state
    logic [1:0]       r_state;
    logic [1:0]       r_col;
    logic [1:0]       r_row;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DB_W-1:0]  r_db_cnt;

    // Outputs
    logic [3:0]       r_key_value;
    logic             r_key_pressed;

    // Decoded conditions
    logic             w_sample;
    logic             w_any_low;
    logic [1:0]       w_low_row;
    logic             w_row_low;
    logic             w_db_last;
    logic             w_press_done;
    logic             w_release_done;
    logic [3:0]       w_enc;

    // Map (row, column) to the printed key legend; '*' shows as E, '#' as F.
    function automatic logic [3:0] f_enc(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'h0:    v = 4'h1;
            4'h1:    v = 4'h2;
            4'h2:    v = 4'h3;
            4'h3:    v = 4'hA;
            4'h4:    v = 4'h4;
            4'h5:    v = 4'h5;
            4'h6:    v = 4'h6;
            4'h7:    v = 4'hB;
            4'h8:    v = 4'h7;
            4'h9:    v = 4'h8;
            4'hA:    v = 4'h9;
            4'hB:    v = 4'hC;
            4'hC:    v = 4'hE;
            4'hD:    v = 4'h0;
            4'hE:    v = 4'hF;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

    assign w_sample       = (r_div_cnt == DIV_LAST);
    assign w_any_low      = (r_row_s != 4'hF);
    assign w_row_low      = ~r_row_s[r_row];
    assign w_db_last      = (r_db_cnt == DB_LAST);
    assign w_press_done   = (r_state == ST_DEBOUNCE) && w_row_low && w_db_last;
    assign w_release_done = (r_state == ST_RELEASE) && !w_row_low && w_db_last;
    assign w_enc          = f_enc(r_row, r_col);

    // One-cold column drive; the column index only moves while scanning,
    // so the drive stays frozen on the owning key's column otherwise.
    assign col_n       = ~(4'b0001 << r_col);
    assign key_value   = r_key_value;
    assign key_pressed = r_key_pressed;

    // Lowest-index low row wins when several rows are low at the sample point.
    always_comb begin
        w_low_row = 2'd3;
        if (!r_row_s[0]) begin
            w_low_row = 2'd0;
        end else if (!r_row_s[1]) begin
            w_low_row = 2'd1;
        end else if (!r_row_s[2]) begin
            w_low_row = 2'd2;
        end
    end

    // Two-flop synchronizer for the asynchronous row inputs; idle level is all-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_sync1 <= 4'hF;
            r_row_s     <= 4'hF;
        end else begin
            r_row_sync1 <= row_n;
            r_row_s     <= r_row_sync1;
        end
    end

    // Scan / debounce / hold / release sequencing with its counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            r_div_cnt <= '0;
            r_db_cnt  <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_sample) begin
                        r_div_cnt <= '0;
                        if (w_any_low) begin
                            // Freeze on this column; the latched row owns the FSM.
                            r_row    <= w_low_row;
                            r_db_cnt <= '0;
                            r_state  <= ST_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_row_low) begin
                        if (w_db_last) begin
                            r_state <= ST_HELD;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_ONE;
                        end
                    end else begin
                        // Bounce: give up on this key and move on.
                        r_state   <= ST_SCAN;
                        r_col     <= r_col + 2'd1;
                        r_div_cnt <= '0;
                    end
                end
                ST_HELD: begin
                    if (!w_row_low) begin
                        r_db_cnt <= '0;
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_row_low) begin
                        if (w_db_last) begin
                            r_state   <= ST_SCAN;
                            r_col     <= r_col + 2'd1;
                            r_div_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + DB_ONE;
                        end
                    end else begin
                        // Release glitch: key is still down.
                        r_state <= ST_HELD;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    // Output level: rises when a press completes debounce, falls when its release does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_value   <= 4'h0;
            r_key_pressed <= 1'b0;
        end else begin
            if (w_press_done) begin
                r_key_value   <= w_enc;
                r_key_pressed <= 1'b1;
            end else if (w_release_done) begin
                r_key_pressed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A keypad matrix model closes the loop from col_n to row_n.
// Expected values come from the key legend table and the timing bounds.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;
    localparam int PRESS_BOUND   = 4 * SD + DB + 3;
    localparam int RELEASE_BOUND = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_value;
    logic       key_pressed;

    // keys[r*4+c] is 1 while the key at row r, column c is physically down
    logic [15:0] keys;

    logic [3:0] ref_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    int n_cmp = 0;
    int n_err = 0;

    // Downstream accumulator model: adds key_value once per key_pressed rise
    int         rises = 0;
    logic       prev_kp = 1'b0;
    logic [11:0] acc = 12'h000;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_value  (key_value),
        .key_pressed(key_pressed)
    );

    // Passive matrix: a row is pulled low by any pressed key on a driven column
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (key_pressed && !prev_kp) begin
            rises = rises + 1;
            acc   = acc + {8'h00, key_value};
        end
        prev_kp = key_pressed;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        rst  = 1'b1;
        keys = 16'h0;
        cyc(2);
        rst = 1'b0;
        cyc(9);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (col_n !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", col_n); end
        n_cmp++;
        if (key_value !== 4'h0) begin n_err++; $display("FAIL reset_value: got %h want 0", key_value); end
        n_cmp++;
        if (key_pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %b want 0", key_pressed); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            n_cmp++;
            if (col_n !== exp_col) begin
                n_err++;
                $display("FAIL scan_walk step %0d: got %b want %b", k, col_n, exp_col);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold;
        int t;
        int r0;
        logic drop;
        r0   = rises;
        keys = 16'h0040;          // r1/c2
        t = 0;
        while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
        n_cmp++;
        if (!key_pressed || t > PRESS_BOUND) begin
            n_err++;
            $display("FAIL hold_latency: got %0d cycles (pressed=%b) want <= %0d", t, key_pressed, PRESS_BOUND);
        end
        n_cmp++;
        if (key_value !== ref_tab[6]) begin n_err++; $display("FAIL hold_value: got %h want %h", key_value, ref_tab[6]); end
        drop = 1'b0;
        for (int i = t; i < 60; i++) begin @(negedge clk); if (!key_pressed) drop = 1'b1; end
        n_cmp++;
        if (drop) begin n_err++; $display("FAIL hold_stable: got drop=1 want 0"); end
        keys = 16'h0;
        t = 0;
        while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
        n_cmp++;
        if (key_pressed || t < DB || t > RELEASE_BOUND) begin
            n_err++;
            $display("FAIL release_timing: got %0d cycles (pressed=%b) want %0d..%0d", t, key_pressed, DB, RELEASE_BOUND);
        end
        cyc(2);
        n_cmp++;
        if (key_value !== 4'h6) begin n_err++; $display("FAIL release_keeps_value: got %h want 6", key_value); end
        n_cmp++;
        if (rises - r0 !== 1) begin n_err++; $display("FAIL hold_rise_count: got %0d want 1", rises - r0); end
    endtask

    task automatic test_bounce;
        int t;
        int r0;
        rst  = 1'b1;
        keys = 16'h0;
        cyc(2);
        rst  = 1'b0;
        keys = 16'h0001;          // r0/c0 while column 0 is driven
        r0   = rises;
        cyc(4);
        keys = 16'h0;
        t = 0;
        while (col_n === 4'b1110 && t < 15) begin @(negedge clk); t++; end
        n_cmp++;
        if (col_n !== 4'b1101) begin n_err++; $display("FAIL bounce_resume_col: got %b want 1101", col_n); end
        cyc(30);
        n_cmp++;
        if (rises - r0 !== 0) begin n_err++; $display("FAIL bounce_no_press: got %0d rises want 0", rises - r0); end
    endtask

    task automatic test_glitch;
        int t;
        int r0;
        logic drop;
        r0   = rises;
        keys = 16'h0010;          // r1/c0 = '4'
        t = 0;
        while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
        n_cmp++;
        if (!key_pressed) begin n_err++; $display("FAIL glitch_press: got 0 want 1"); end
        cyc(5);
        drop = 1'b0;
        keys = 16'h0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (!key_pressed) drop = 1'b1; end
        keys = 16'h0010;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (!key_pressed) drop = 1'b1; end
        n_cmp++;
        if (drop) begin n_err++; $display("FAIL glitch_stays_high: got drop=1 want 0"); end
        n_cmp++;
        if (key_value !== 4'h4) begin n_err++; $display("FAIL glitch_value: got %h want 4", key_value); end
        keys = 16'h0;
        t = 0;
        while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
        n_cmp++;
        if (rises - r0 !== 1 || key_pressed) begin
            n_err++;
            $display("FAIL glitch_single_rise: got %0d rises (pressed=%b) want 1", rises - r0, key_pressed);
        end
        cyc(4);
    endtask

    task automatic test_two_keys;
        int t;
        logic drop;
        keys = 16'h0001;          // '1'
        t = 0;
        while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
        n_cmp++;
        if (!key_pressed || key_value !== 4'h1) begin
            n_err++;
            $display("FAIL two_first: got pressed=%b value=%h want 1/1", key_pressed, key_value);
        end
        keys = 16'h0401;          // add '9' at r2/c2
        drop = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (!key_pressed) drop = 1'b1; end
        n_cmp++;
        if (drop || key_value !== 4'h1) begin
            n_err++;
            $display("FAIL two_owner: got drop=%b value=%h want 0/1", drop, key_value);
        end
        keys = 16'h0400;          // release '1', keep '9'
        t = 0;
        while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
        n_cmp++;
        if (key_pressed) begin n_err++; $display("FAIL two_fall: got 1 want 0"); end
        t = 0;
        while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
        n_cmp++;
        if (!key_pressed || key_value !== 4'h9) begin
            n_err++;
            $display("FAIL two_second: got pressed=%b value=%h want 1/9", key_pressed, key_value);
        end
        keys = 16'h0;
        t = 0;
        while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
        cyc(4);
    endtask

    task automatic test_sweep;
        int t;
        logic [11:0] base;
        base = acc;
        for (int k = 0; k < 16; k++) begin
            keys = 16'h0001 << k;
            t = 0;
            while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
            n_cmp++;
            if (!key_pressed || key_value !== ref_tab[k]) begin
                n_err++;
                $display("FAIL sweep key %0d: got pressed=%b value=%h want 1/%h", k, key_pressed, key_value, ref_tab[k]);
            end
            cyc(5);
            keys = 16'h0;
            t = 0;
            while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
            cyc(3);
        end
        n_cmp++;
        if (acc - base !== 12'h078) begin n_err++; $display("FAIL sweep_sum: got %h want 078", acc - base); end
    endtask

    task automatic test_random;
        int t;
        int r0;
        int k;
        int b;
        for (int it = 0; it < 10; it++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                // Short bounce (< DB cycles low) on some key must never register
                b = $urandom_range(0, 15);
                keys = 16'h0001 << b;
                cyc($urandom_range(1, DB - 2));
                keys = 16'h0;
                cyc($urandom_range(12, 20));
            end
            r0   = rises;
            keys = 16'h0001 << k;
            cyc($urandom_range(PRESS_BOUND + 8, 60));
            n_cmp++;
            if (key_pressed !== 1'b1 || key_value !== ref_tab[k]) begin
                n_err++;
                $display("FAIL random it %0d key %0d: got pressed=%b value=%h want 1/%h", it, k, key_pressed, key_value, ref_tab[k]);
            end
            if ($urandom_range(0, 1) == 1) begin
                keys = 16'h0;
                cyc($urandom_range(1, 3));
                keys = 16'h0001 << k;
                cyc(10);
            end
            keys = 16'h0;
            t = 0;
            while (key_pressed && t < RELEASE_BOUND + 6) begin @(negedge clk); t++; end
            n_cmp++;
            if (key_pressed || rises - r0 !== 1) begin
                n_err++;
                $display("FAIL random_once it %0d: got %0d rises (pressed=%b) want 1", it, rises - r0, key_pressed);
            end
            cyc($urandom_range(5, 15));
        end
        // Reset while a key is held
        keys = 16'h0020;          // '5'
        t = 0;
        while (!key_pressed && t < PRESS_BOUND + 3) begin @(negedge clk); t++; end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (key_pressed !== 1'b0 || key_value !== 4'h0 || col_n !== 4'b1110) begin
            n_err++;
            $display("FAIL midreset: got pressed=%b value=%h col=%b want 0/0/1110", key_pressed, key_value, col_n);
        end
        keys = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        cyc(4);
    endtask

    initial begin
        rst  = 1'b1;
        keys = 16'h0;
        test_reset();
        test_hold();
        test_bounce();
        test_glitch();
        test_two_keys();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
